// File: rtl/module_return_task_sched.sv
// Round-robin scheduler sharing one increment-with-early-return unit between NUM_REQ requesters.
// A three-state FSM (IDLE/RUN/DONE) iterates f(v) per job and returns the result on a valid/ready port.
module module_return_task_sched #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int THRESH    = 10,
    parameter int MAX_STEPS = 4,
    parameter int SW        = $clog2(MAX_STEPS + 1),
    parameter int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ*SW-1:0]    req_steps,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [IDW-1:0]           out_id,
    output logic                     out_early,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [WIDTH:0]  THRESH_W = (WIDTH+1)'(THRESH);
    localparam logic [SW-1:0]   MAX_S    = SW'(MAX_STEPS);
    localparam logic [IDW-1:0]  PTR_INIT = IDW'(NUM_REQ - 1);

    state_t             state, state_nxt;
    logic [IDW-1:0]     rr_ptr;
    logic [WIDTH-1:0]   acc;
    logic [SW-1:0]      cnt;
    logic [SW-1:0]      steps;
    logic [IDW-1:0]     id;
    logic               early;

    logic [WIDTH-1:0]   data_arr  [NUM_REQ];
    logic [SW-1:0]      steps_arr [NUM_REQ];
    logic               grant_vld;
    logic [IDW-1:0]     grant_idx;
    logic [IDW-1:0]     cand;
    logic [SW-1:0]      sel_steps;
    logic [SW-1:0]      cnt_inc;
    logic [WIDTH:0]     step_res;
    logic               fired;

    // One f evaluation; MSB flags the clamp. The sum is WIDTH+1 bits wide so v=max never wraps.
    function automatic logic [WIDTH:0] f_step(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] t;
        t = {1'b0, v} + {{WIDTH{1'b0}}, 1'b1};
        if (t > THRESH_W)
            return {1'b1, {WIDTH{1'b0}}};
        else
            return {1'b0, t[WIDTH-1:0]};
    endfunction

    function automatic logic [SW-1:0] clamp_steps(input logic [SW-1:0] s);
        return (s > MAX_S) ? MAX_S : s;
    endfunction

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i]  = req_data[i*WIDTH +: WIDTH];
        assign steps_arr[i] = req_steps[i*SW +: SW];
    end

    // Search starts just above the last-served requester, so it becomes lowest priority.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IDW'((int'(rr_ptr) + off) % NUM_REQ);
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign sel_steps = clamp_steps(steps_arr[grant_idx]);
    assign step_res  = f_step(acc);
    assign fired     = step_res[WIDTH];
    assign cnt_inc   = cnt + SW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant_vld) state_nxt = (sel_steps == '0) ? DONE : RUN;
            RUN:  if (fired || (cnt_inc == steps)) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_vld)
            req_ready[grant_idx] = 1'b1;
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    assign out_data  = acc;
    assign out_id    = id;
    assign out_early = early;

    // Job registers are reset too: they drive the result port directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= PTR_INIT;
            acc    <= '0;
            cnt    <= '0;
            steps  <= '0;
            id     <= '0;
            early  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (grant_vld) begin
                    acc   <= data_arr[grant_idx];
                    cnt   <= '0;
                    steps <= sel_steps;
                    id    <= grant_idx;
                    early <= 1'b0;
                end
                RUN: begin
                    acc <= step_res[WIDTH-1:0];
                    if (fired)
                        early <= 1'b1;
                    else
                        cnt <= cnt_inc;
                end
                DONE: if (out_ready) rr_ptr <= id;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_module_return_task_sched.sv
// Directed bench for module_return_task_sched: each step checks outputs against hand-computed values.
module tb_module_return_task_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_data;
    logic [11:0] req_steps;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic        out_early;
    logic        busy;

    logic [7:0]  dat [4];
    logic [2:0]  stp [4];

    int n_cmp = 0;
    int n_err = 0;

    assign req_data  = {dat[3], dat[2], dat[1], dat[0]};
    assign req_steps = {stp[3], stp[2], stp[1], stp[0]};

    module_return_task_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_steps (req_steps),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_early (out_early),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single requester job with out_ready=1; k = expected cycles from accept to out_valid.
    task automatic run_job(input logic [1:0] idx, input logic [7:0] d, input logic [2:0] s,
                           input logic [7:0] ed, input logic ee, input int k);
        logic [3:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        dat[idx]  = d;
        stp[idx]  = s;
        req_valid = oh;
        out_ready = 1'b1;
        #1;
        check("job_ready", {28'd0, req_ready}, {28'd0, oh});
        tick();
        req_valid = '0;
        check("job_busy", {31'd0, busy}, 32'd1);
        check("job_ready_run", {28'd0, req_ready}, 32'd0);
        for (int c = 1; c < k; c++) begin
            check("job_wait_valid", {31'd0, out_valid}, 32'd0);
            tick();
        end
        if (k > 1 || s != 3'd0) begin
            if (k == 1) check("job_wait_valid", {31'd0, out_valid}, 32'd0);
            tick();
        end
        check("job_valid", {31'd0, out_valid}, 32'd1);
        check("job_data", {24'd0, out_data}, {24'd0, ed});
        check("job_id", {30'd0, out_id}, {30'd0, idx});
        check("job_early", {31'd0, out_early}, {31'd0, ee});
        tick();
        check("job_valid_drop", {31'd0, out_valid}, 32'd0);
        check("job_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dat[i] = '0;
            stp[i] = '0;
        end
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_out_id", {30'd0, out_id}, 32'd0);
        check("rst_out_early", {31'd0, out_early}, 32'd0);
        check("rst_first_grant", {28'd0, req_ready}, 32'h1);
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();

        // 3+1+1 = 5 after two RUN cycles
        run_job(2'd0, 8'd3, 3'd2, 8'd5, 1'b0, 2);
        // 9 -> 10, then 11 > 10 clamps at the second step
        run_job(2'd1, 8'd9, 3'd4, 8'd0, 1'b1, 2);
        // 255 + 1 = 256 in 9 bits, no wrap to 0
        run_job(2'd2, 8'd255, 3'd1, 8'd0, 1'b1, 1);
        // steps 7 is limited to 4: 0 -> 4
        run_job(2'd3, 8'd0, 3'd7, 8'd4, 1'b0, 4);
        // t == THRESH does not clamp
        run_job(2'd3, 8'd9, 3'd1, 8'd10, 1'b0, 1);

        // Round robin with all requesters valid and zero steps
        for (int i = 0; i < 4; i++) begin
            dat[i] = 8'(i);
            stp[i] = 3'd0;
        end
        req_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        for (int j = 0; j < 5; j++) begin
            logic [3:0] oh;
            logic [1:0] g;
            g  = 2'(j % 4);
            oh = '0;
            oh[g] = 1'b1;
            check("rr_ready", {28'd0, req_ready}, {28'd0, oh});
            tick();
            check("rr_valid", {31'd0, out_valid}, 32'd1);
            check("rr_id", {30'd0, out_id}, {30'd0, g});
            check("rr_data", {24'd0, out_data}, {30'd0, g});
            check("rr_ready_done", {28'd0, req_ready}, 32'd0);
            tick();
        end
        req_valid = '0;
        tick();

        // Back-pressure: rr_ptr is 0, so req1 wins among 1..3
        for (int i = 0; i < 4; i++) begin
            dat[i] = 8'd2;
            stp[i] = 3'd1;
        end
        out_ready = 1'b0;
        req_valid = 4'b1110;
        #1;
        check("bp_ready", {28'd0, req_ready}, 32'h2);
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_data", {24'd0, out_data}, 32'd3);
            check("bp_id", {30'd0, out_id}, 32'd1);
            check("bp_early", {31'd0, out_early}, 32'd0);
            check("bp_ready_zero", {28'd0, req_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_next_grant", {28'd0, req_ready}, 32'h4);
        tick();
        req_valid = '0;
        tick();
        check("bp_second_valid", {31'd0, out_valid}, 32'd1);
        check("bp_second_id", {30'd0, out_id}, 32'd2);
        check("bp_second_data", {24'd0, out_data}, 32'd3);
        tick();

        // Asynchronous reset while a 4-step job is in RUN
        dat[3] = 8'd0;
        stp[3] = 3'd4;
        req_valid = 4'b1000;
        #1;
        check("ar_ready", {28'd0, req_ready}, 32'h8);
        tick();
        req_valid = '0;
        tick();
        check("ar_busy_run", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", {31'd0, out_valid}, 32'd0);
        check("ar_busy", {31'd0, busy}, 32'd0);
        check("ar_data", {24'd0, out_data}, 32'd0);
        for (int i = 0; i < 4; i++) stp[i] = 3'd0;
        req_valid = 4'b1111;
        #1;
        check("ar_next_grant", {28'd0, req_ready}, 32'h1);
        tick();
        rst_n = 1'b1;
        #1;
        tick();
        check("ar_after_valid", {31'd0, out_valid}, 32'd1);
        check("ar_after_id", {30'd0, out_id}, 32'd0);
        req_valid = '0;
        tick();
        check("ar_after_drop", {31'd0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
